step_counter_5bit: RTL and testbench
====================================

// Module: step_counter_5bit
// PURPOSE
//  Sequencing stage that drives the 5-bit add/subtract datapath. It holds a count register
//  and steps it up or down by a programmable step until it reaches a target, then pulses done.
//  Each cycle it computes count±step through the add/sub datapath and registers the result.
//  It sits between the control/stimulus logic and any consumer of count.
// PARAMETERS
//  WIDTH   5   count/step/target width; only 5 is supported
// PORTS
//  clk       in   1  rising-edge clock, the block's only clock
//  rst_n     in   1  asynchronous active-low reset
//  start     in   1  begin a run (sampled in IDLE only)
//  stop      in   1  abort the run (sampled in RUN only)
//  load      in   1  load count from load_val (sampled in IDLE only)
//  load_val  in   5  value written to count by load
//  dir       in   1  direction: 0 = up (count+step), 1 = down (count-step); latched at start
//  step      in   5  step size, latched at start; a value of 0 is latched as 1
//  target    in   5  end value, latched at start
//  count     out  5  current count register
//  busy      out  1  1 while in RUN
//  done      out  1  one-cycle pulse when a run completes
//  ovf       out  1  sticky wrap flag; cleared by start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, count=0, busy=0, done=0, ovf=0, latched regs=0.
//   Reset mid-run aborts immediately, with no done pulse.
//  FSM IDLE->RUN->DONE->IDLE:
//   IDLE: load=1 -> count<=load_val, stay in IDLE. load has priority over start in the same cycle.
//    start=1 (load=0) -> latch dir/step/target, ovf<=0, go to RUN. count is unchanged.
//   RUN: busy=1; start and load are ignored.
//    stop=1 -> IDLE next edge, count holds, no done. stop beats every other RUN action.
//    Otherwise compute rem = dir ? count-target : target-count (mod 32).
//     rem <= step -> count<=target, go to DONE. This includes rem=0, i.e. count==target at start.
//     else -> count<=count±step (mod 32).
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//  Arithmetic:
//   Subtraction is a + ~b with carry-in 1.
//   Wrap: up carry-out=1, or down carry-out=0.
//   Final step wraps: up with target<count, or down with target>count.
//   Any wrap on an applied step sets ovf.
//  Latency: start at edge k; the first count update at edge k+1. Each later RUN edge adds one step.
//   done is high in the cycle after the final update.
// CONFIGURATION
//  SATURATE_EN defined: a non-final step that wraps clamps count to 31 (up) or 0 (down).
//   It also sets ovf and goes to DONE without reaching target.
//  SATURATE_EN undefined: count wraps modulo 32, ovf is set, RUN continues until target.
// STRUCTURE
//  counter_pkg holds: WIDTH=5, the state enum (IDLE/RUN/DONE, 2-bit encoding) and CNT_MAX=31.
//  Sub-module addsub_5bit (a, b, mode -> sum, cout) is a combinational adder/subtractor.
//   Two instances: one for next count, one for rem.
//  The comparison rem<=step, the FSM and the registers live in this module.
// TESTING
//  1 up 3->12, step 3: count 6, 9, 12; done pulses one cycle after 12; ovf=0.
//  2 down 10->1, step 4: count 6, 2, 1 (final clamp to target); done; ovf=0.
//  3 up 30->2, step 1, no macro: count 31, 0, 1, 2; done; ovf=1.
//    With SATURATE_EN: count 31, then 31 held; done; ovf=1.
//  4 start with count==target=7, step 5: one RUN cycle, count stays 7, done. Step 0 acts as 1.
//  5 stop during RUN at count=9: IDLE next edge, count=9, no done.
//    load=1 with start=1 in IDLE: count=load_val, state stays IDLE.
//  6 rst_n low mid-run, asynchronously: count=0, busy=0, done=0 immediately.
//    start during RUN is ignored.

Source files
------------

// File: rtl/step_counter_5bit_pkg.sv
// Shared types and constants for the 5-bit step counter.
// Optional build macro used by the top: SATURATE_EN.
package step_counter_5bit_pkg;

    localparam int WIDTH = 5;
    localparam logic [WIDTH-1:0] CNT_MAX = 5'd31;
    localparam logic [WIDTH-1:0] CNT_ZERO = 5'd0;
    localparam logic [WIDTH-1:0] STEP_ONE = 5'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Up steps wrap on carry-out; down steps (a + ~b + 1) wrap on a missing carry.
    function automatic logic step_wrapped(input logic dir_down, input logic cout);
        return dir_down ? ~cout : cout;
    endfunction

    // Final clamp to target passes through 0/31 when target lies behind count.
    function automatic logic final_wrapped(input logic dir_down,
                                           input logic [WIDTH-1:0] cnt,
                                           input logic [WIDTH-1:0] tgt);
        return dir_down ? (tgt > cnt) : (tgt < cnt);
    endfunction

endpackage

// File: rtl/step_counter_5bit_if.sv
// Control/status bundle between the stimulus logic (master) and the step counter (slave).
interface step_counter_5bit_if;
    import step_counter_5bit_pkg::*;

    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, stop, load, load_val, dir, step, target,
        input  count, busy, done, ovf
    );

    modport slave (
        input  start, stop, load, load_val, dir, step, target,
        output count, busy, done, ovf
    );

endinterface

// File: rtl/step_counter_5bit_addsub.sv
// Combinational 5-bit adder/subtractor; mode=1 computes a + ~b + 1.
module addsub_5bit
    import step_counter_5bit_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   full_s;

    assign b_eff_s = mode_i ? ~b_i : b_i;
    assign full_s  = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, mode_i};
    assign sum_o   = full_s[WIDTH-1:0];
    assign cout_o  = full_s[WIDTH];

endmodule

// File: rtl/step_counter_5bit.sv
// Step counter: walks count toward target by a latched step, then pulses done.
// Build with SATURATE_EN to clamp a wrapping intermediate step and finish early.
module step_counter_5bit
    import step_counter_5bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    step_counter_5bit_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] next_cnt_s;
    logic             next_cout_s;
    logic [WIDTH-1:0] rem_s;
    logic             rem_cout_unused_s;
    logic [WIDTH-1:0] rem_a_s;
    logic [WIDTH-1:0] rem_b_s;

    addsub_5bit u_step (
        .a_i    (count_q),
        .b_i    (step_q),
        .mode_i (dir_q),
        .sum_o  (next_cnt_s),
        .cout_o (next_cout_s)
    );

    // Distance still to travel, always measured in the direction of motion.
    assign rem_a_s = dir_q ? count_q : target_q;
    assign rem_b_s = dir_q ? target_q : count_q;

    addsub_5bit u_rem (
        .a_i    (rem_a_s),
        .b_i    (rem_b_s),
        .mode_i (1'b1),
        .sum_o  (rem_s),
        .cout_o (rem_cout_unused_s)
    );

    // Next-state, datapath and flag decisions.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        step_d   = step_q;
        target_d = target_q;
        dir_d    = dir_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    count_d = bus.load_val;
                end else if (bus.start) begin
                    dir_d    = bus.dir;
                    step_d   = (bus.step == CNT_ZERO) ? STEP_ONE : bus.step;
                    target_d = bus.target;
                    ovf_d    = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (rem_s <= step_q) begin
                    count_d = target_q;
                    state_d = DONE;
                    if (final_wrapped(dir_q, count_q, target_q)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end else if (step_wrapped(dir_q, next_cout_s)) begin
                    ovf_d = 1'b1;
`ifdef SATURATE_EN
                    count_d = dir_q ? CNT_ZERO : CNT_MAX;
                    state_d = DONE;
`else
                    count_d = next_cnt_s;
`endif
                end else begin
                    count_d = next_cnt_s;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            step_q   <= CNT_ZERO;
            target_q <= CNT_ZERO;
            dir_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            step_q   <= step_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_step_counter_5bit.sv
// Directed self-checking bench for step_counter_5bit (honours SATURATE_EN if defined).
module tb_step_counter_5bit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    step_counter_5bit_if bus ();

    step_counter_5bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] c, input logic b,
                          input logic d, input logic o);
        chk({tag, ".count"}, {3'd0, bus.count}, {3'd0, c});
        chk({tag, ".busy"},  {7'd0, bus.busy},  {7'd0, b});
        chk({tag, ".done"},  {7'd0, bus.done},  {7'd0, d});
        chk({tag, ".ovf"},   {7'd0, bus.ovf},   {7'd0, o});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] v);
        bus.load = 1'b1;
        bus.load_val = v;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic [4:0] s, input logic [4:0] t);
        bus.start = 1'b1;
        bus.dir = d;
        bus.step = s;
        bus.target = t;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.load = 1'b0;
        bus.load_val = 5'd0;
        bus.dir = 1'b0;
        bus.step = 5'd0;
        bus.target = 5'd0;
        #3;
        chk_st("reset", 5'd0, 1'b0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // 1: up 3 -> 12 step 3
        do_load(5'd3);
        chk_st("t1.load", 5'd3, 1'b0, 1'b0, 1'b0);
        do_start(1'b0, 5'd3, 5'd12);
        chk_st("t1.start", 5'd3, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t1.s1", 5'd6, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t1.s2", 5'd9, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t1.s3", 5'd12, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("t1.idle", 5'd12, 1'b0, 1'b0, 1'b0);

        // 2: down 10 -> 1 step 4
        do_load(5'd10);
        do_start(1'b1, 5'd4, 5'd1);
        chk_st("t2.start", 5'd10, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t2.s1", 5'd6, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t2.s2", 5'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t2.s3", 5'd1, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("t2.idle", 5'd1, 1'b0, 1'b0, 1'b0);

        // 3: up 30 -> 2 step 1 (wrap)
        do_load(5'd30);
        do_start(1'b0, 5'd1, 5'd2);
        tick(); chk_st("t3.s1", 5'd31, 1'b1, 1'b0, 1'b0);
`ifdef SATURATE_EN
        tick(); chk_st("t3.sat", 5'd31, 1'b0, 1'b1, 1'b1);
        tick(); chk_st("t3.idle", 5'd31, 1'b0, 1'b0, 1'b1);
`else
        tick(); chk_st("t3.s2", 5'd0, 1'b1, 1'b0, 1'b1);
        tick(); chk_st("t3.s3", 5'd1, 1'b1, 1'b0, 1'b1);
        tick(); chk_st("t3.s4", 5'd2, 1'b0, 1'b1, 1'b1);
        tick(); chk_st("t3.idle", 5'd2, 1'b0, 1'b0, 1'b1);
`endif

        // 4: count == target at start; start clears ovf
        do_load(5'd7);
        do_start(1'b0, 5'd5, 5'd7);
        chk_st("t4.start", 5'd7, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t4.fin", 5'd7, 1'b0, 1'b1, 1'b0);
        tick(); chk_st("t4.idle", 5'd7, 1'b0, 1'b0, 1'b0);
        // 4b: step 0 behaves as step 1
        do_start(1'b0, 5'd0, 5'd9);
        tick(); chk_st("t4b.s1", 5'd8, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t4b.s2", 5'd9, 1'b0, 1'b1, 1'b0);
        tick();
        // 4c: final step wraps down past zero
        do_load(5'd1);
        do_start(1'b1, 5'd3, 5'd30);
        tick(); chk_st("t4c.fin", 5'd30, 1'b0, 1'b1, 1'b1);
        tick();

        // 5: stop mid-run at 9
        do_load(5'd3);
        do_start(1'b0, 5'd3, 5'd20);
        tick(); chk_st("t5.s1", 5'd6, 1'b1, 1'b0, 1'b0);
        tick(); chk_st("t5.s2", 5'd9, 1'b1, 1'b0, 1'b0);
        bus.stop = 1'b1;
        tick(); chk_st("t5.stop", 5'd9, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b0;
        tick(); chk_st("t5.hold", 5'd9, 1'b0, 1'b0, 1'b0);
        // 5b: load beats start in IDLE
        bus.load = 1'b1;
        bus.start = 1'b1;
        bus.load_val = 5'd17;
        tick(); chk_st("t5b.ld", 5'd17, 1'b0, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.start = 1'b0;
        tick(); chk_st("t5b.idle", 5'd17, 1'b0, 1'b0, 1'b0);

        // 6: start ignored in RUN, then async reset mid-run
        do_load(5'd0);
        do_start(1'b0, 5'd2, 5'd20);
        bus.start = 1'b1;
        bus.dir = 1'b1;
        bus.step = 5'd5;
        bus.target = 5'd0;
        tick(); chk_st("t6.s1", 5'd2, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); chk_st("t6.s2", 5'd4, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_st("t6.rst", 5'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_st("t6.held", 5'd0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        tick(); tick(); chk_st("t6.after", 5'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
